// File: rtl/cc_capture_sequencer.sv
// cc_capture_sequencer
//
// Sequences multi-frame capture bursts on the CMOS capture host. For every
// frame it waits for a free downstream buffer, pulses the host's arm request,
// follows the host's cc_enabled window and then validates the host's
// bits-per-frame statistic. Between captures it can let a programmable number
// of vsync rising edges pass. Waits in ARM and SKIP are bounded by a timeout.
//
// Ports (all in the cmos_clk_i domain):
//   cmos_clk_i        sensor pixel clock
//   rst               asynchronous active-high reset
//   start_i           pulse, starts a burst from IDLE
//   abort_i           ends a running burst with err_code 2
//   num_frames_i      frames to accept (0 = run until abort), latched at start
//   skip_frames_i     vsync rises to skip between captures, latched on SKIP entry
//   expected_bits_i   required bits_per_frame (0 = accept anything)
//   cmos_vsync_i      raw sensor vsync
//   buf_ready_i       downstream buffer free
//   cc_enabled_i      capture window from the host
//   bits_per_frame_i  host statistic, valid in CHECK
//   arm_o             arm request to the host
//   frame_done_o      one-cycle pulse per accepted frame
//   busy_o            high whenever a burst is running
//   done_o            one-cycle pulse at burst end
//   error_o           sticky error flag, cleared by the next start
//   err_code_o        0 none, 1 timeout, 2 abort
//   frames_captured_o accepted-frame count (saturating)
//   frames_dropped_o  rejected-frame count (saturating)
module cc_capture_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
  parameter int          CNT_W          = 16
) (
  input  logic             cmos_clk_i,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_frames_i,
  input  logic [7:0]       skip_frames_i,
  input  logic [31:0]      expected_bits_i,
  input  logic             cmos_vsync_i,
  input  logic             buf_ready_i,
  input  logic             cc_enabled_i,
  input  logic [31:0]      bits_per_frame_i,
  output logic             arm_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] frames_captured_o,
  output logic [CNT_W-1:0] frames_dropped_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUF,
    S_ARM,
    S_CAPTURE,
    S_CHECK,
    S_SKIP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic             vsync_p1;
  logic             cc_en_p1;
  logic [31:0]      tmo_cnt;
  logic [7:0]       skip_cnt;
  logic [CNT_W-1:0] num_lat;

  logic             vsync_rise;
  logic             cc_fall;
  logic             timed_out;
  logic             bits_bad;
  logic             check_act;
  logic             set_err;
  logic [1:0]       err_d;
  logic [CNT_W-1:0] cap_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign vsync_rise = cmos_vsync_i & ~vsync_p1;
  assign cc_fall    = cc_en_p1 & ~cc_enabled_i;
  assign timed_out  = (tmo_cnt >= TIMEOUT_CYCLES);
  assign bits_bad   = (expected_bits_i != 32'd0) && (bits_per_frame_i != expected_bits_i);
  // A frame is judged only when CHECK is not pre-empted by abort.
  assign check_act  = (state_q == S_CHECK) && !abort_i;
  assign cap_next   = bits_bad ? frames_captured_o : sat_inc(frames_captured_o);
  assign busy_o     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    err_d   = 2'd0;
    if (state_q != S_IDLE && state_q != S_DONE && abort_i) begin
      state_d = S_DONE;
      set_err = 1'b1;
      err_d   = 2'd2;
    end else begin
      case (state_q)
        S_IDLE:     if (start_i) state_d = S_WAIT_BUF;
        S_WAIT_BUF: if (buf_ready_i) state_d = S_ARM;
        S_ARM: begin
          if (cc_enabled_i) begin
            state_d = S_CAPTURE;
          end else if (timed_out) begin
            state_d = S_DONE;
            set_err = 1'b1;
            err_d   = 2'd1;
          end
        end
        S_CAPTURE:  if (cc_fall) state_d = S_CHECK;
        S_CHECK: begin
          if (num_lat != '0 && cap_next == num_lat) state_d = S_DONE;
          else if (skip_frames_i != 8'd0)            state_d = S_SKIP;
          else                                       state_d = S_WAIT_BUF;
        end
        S_SKIP: begin
          if (vsync_rise && skip_cnt <= 8'd1) begin
            state_d = S_WAIT_BUF;
          end else if (timed_out) begin
            state_d = S_DONE;
            set_err = 1'b1;
            err_d   = 2'd1;
          end
        end
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // ---- state register and edge-detect history ----
  always_ff @(posedge cmos_clk_i or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vsync_p1 <= 1'b0;
      cc_en_p1 <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_p1 <= cmos_vsync_i;
      cc_en_p1 <= cc_enabled_i;
    end
  end

  // ---- timeout, skip counter and burst length latch ----
  always_ff @(posedge cmos_clk_i or posedge rst) begin
    if (rst) begin
      tmo_cnt  <= 32'd0;
      skip_cnt <= 8'd0;
      num_lat  <= '0;
    end else begin
      if (state_d != state_q)
        tmo_cnt <= 32'd0;
      else if ((state_q == S_ARM || state_q == S_SKIP) && !(&tmo_cnt))
        tmo_cnt <= tmo_cnt + 32'd1;

      if (state_q != S_SKIP && state_d == S_SKIP)
        skip_cnt <= skip_frames_i;
      else if (state_q == S_SKIP && vsync_rise && skip_cnt != 8'd0)
        skip_cnt <= skip_cnt - 8'd1;

      if (state_q == S_IDLE && start_i)
        num_lat <= num_frames_i;
    end
  end

  // ---- registered outputs ----
  // arm_o rises one cycle after ARM entry and drops on the edge that leaves ARM.
  always_ff @(posedge cmos_clk_i or posedge rst) begin
    if (rst) begin
      arm_o             <= 1'b0;
      frame_done_o      <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
      err_code_o        <= 2'd0;
      frames_captured_o <= '0;
      frames_dropped_o  <= '0;
    end else begin
      arm_o        <= (state_q == S_ARM) && (state_d == S_ARM);
      frame_done_o <= check_act && !bits_bad;
      done_o       <= (state_d == S_DONE);

      if (state_q == S_IDLE && start_i) begin
        frames_captured_o <= '0;
        frames_dropped_o  <= '0;
        error_o           <= 1'b0;
        err_code_o        <= 2'd0;
      end else begin
        if (check_act) begin
          if (bits_bad) frames_dropped_o  <= sat_inc(frames_dropped_o);
          else          frames_captured_o <= cap_next;
        end
        if (set_err) begin
          err_code_o <= err_d;
          error_o    <= 1'b1;
        end
      end
    end
  end

endmodule
